// File: rtl/tower_pkg.sv
// Shared constants, types and helpers for the tower-stacking game blocks.
// Contents:
//   SCREEN_W / BLOCK_W / NUM_ROWS  - playfield geometry and tower height
//   LOW / MID / HIGH / MAX         - difficulty settings (frames per pixel step)
//   GO_LEFT / GO_RIGHT             - block direction encoding
//   state_t                        - block_mover game-state enum
//   max9 / min9                    - 9-bit helpers for the overlap test
package tower_pkg;

    localparam int SCREEN_W = 160;
    localparam int BLOCK_W  = 16;
    localparam int NUM_ROWS = 7;

    localparam logic [2:0] LOW  = 3'd4;
    localparam logic [2:0] MID  = 3'd3;
    localparam logic [2:0] HIGH = 3'd2;
    localparam logic [2:0] MAX  = 3'd1;

    localparam logic GO_LEFT  = 1'b0;
    localparam logic GO_RIGHT = 1'b1;

    localparam logic [6:0] RESET_Y = 7'd104;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MOVE,
        CHECK,
        NEXT,
        WAIT,
        GAME_OVER,
        GAME_WON
    } state_t;

    function automatic logic [8:0] max9(input logic [8:0] a, input logic [8:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [8:0] min9(input logic [8:0] a, input logic [8:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/block_mover_if.sv
// Signal bundle between block_mover, its row_counter / control sources and the draw stage.
// Modports:
//   master - drives start, frame_tick, drop, difficulty, new_*; observes block outputs
//   slave  - block_mover side: consumes the controls, drives inc_row, x/y/width,
//            busy, game_over, game_won, perfect_count
interface block_mover_if;

    logic       start;
    logic       frame_tick;
    logic       drop;
    logic [2:0] difficulty;
    logic       new_direction;
    logic [7:0] new_x_position;
    logic [6:0] new_y_position;

    logic       inc_row;
    logic [7:0] x_position;
    logic [6:0] y_position;
    logic [7:0] block_width;
    logic       busy;
    logic       game_over;
    logic       game_won;
    logic [2:0] perfect_count;

    modport master (
        output start, frame_tick, drop, difficulty,
               new_direction, new_x_position, new_y_position,
        input  inc_row, x_position, y_position, block_width,
               busy, game_over, game_won, perfect_count
    );

    modport slave (
        input  start, frame_tick, drop, difficulty,
               new_direction, new_x_position, new_y_position,
        output inc_row, x_position, y_position, block_width,
               busy, game_over, game_won, perfect_count
    );

endinterface

// File: rtl/frame_divider.sv
// Divides frame_tick down to one-cycle step pulses, one per `difficulty` ticks.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clear       - holds the frame count at zero
//   frame_tick  - one-cycle pulse per video frame
//   difficulty  - frames per step; 0 behaves as 1
//   step        - one-cycle pulse on the tick that completes a period
module frame_divider
    import tower_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       frame_tick,
    input  logic [2:0] difficulty,
    output logic       step
);

    logic [2:0] count;
    logic [2:0] period;
    logic [3:0] count_inc;

    // NOTE: every signal written here gets a value before any condition, so no latch is inferred.
    always_comb begin
        period    = (difficulty == 3'd0) ? MAX : difficulty;
        count_inc = {1'b0, count} + 4'd1;
        step      = frame_tick && (count_inc >= {1'b0, period});
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (step) begin
            count <= '0;
        end else if (frame_tick) begin
            count <= count_inc[2:0];
        end
    end

endmodule

// File: rtl/block_mover.sv
// Moves the current row's block left/right, bouncing at the screen edges, and on a
// player drop trims it to the overlap with the row below, then pulses inc_row.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (shared with row_counter)
//   bus         - block_mover_if.slave: start/frame_tick/drop/difficulty/new_* in;
//                 inc_row, x_position, y_position, block_width, busy,
//                 game_over, game_won, perfect_count out
// Build option: define BLOCK_MOVER_PERFECT_EN to count perfect drops
// (exact x and width match on rows above 0, saturating at 7); otherwise
// perfect_count is tied to 0.
module block_mover
    import tower_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    block_mover_if.slave bus
);

    state_t     state, state_next;
    logic [7:0] x_pos;
    logic [6:0] y_pos;
    logic [7:0] blk_w;
    logic       dir;
    logic [2:0] row;
    logic [7:0] prev_x;
    logic [7:0] prev_w;
    logic       over_flag;
    logic       won_flag;
    logic       step;

    logic [8:0] right_limit;
    logic [8:0] overlap_l;
    logic [8:0] overlap_r;
    logic       overlap_ok;
    logic       last_row;
    logic [7:0] trim_x;
    logic [7:0] trim_w;

    frame_divider u_frame_divider (
        .clk        (clk),
        .reset      (reset),
        .clear      (state != MOVE),
        // A drop in the same cycle as a tick suppresses the step.
        .frame_tick (bus.frame_tick && !bus.drop && (state == MOVE)),
        .difficulty (bus.difficulty),
        .step       (step)
    );

    always_comb begin
        right_limit = 9'(SCREEN_W) - {1'b0, blk_w};
        overlap_l   = max9({1'b0, x_pos}, {1'b0, prev_x});
        overlap_r   = min9({1'b0, x_pos} + {1'b0, blk_w}, {1'b0, prev_x} + {1'b0, prev_w});
        overlap_ok  = (row == 3'd0) || (overlap_r > overlap_l);
        last_row    = (row == 3'(NUM_ROWS - 1));
        // Row 0 has nothing below it, so it keeps its position and width.
        if (row == 3'd0) begin
            trim_x = x_pos;
            trim_w = blk_w;
        end else begin
            trim_x = overlap_l[7:0];
            trim_w = 8'(overlap_r - overlap_l);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:      if (bus.start) state_next = LOAD;
            LOAD:      state_next = MOVE;
            MOVE:      if (bus.drop) state_next = CHECK;
            CHECK: begin
                if (!overlap_ok)   state_next = GAME_OVER;
                else if (last_row) state_next = GAME_WON;
                else               state_next = NEXT;
            end
            NEXT:      state_next = WAIT;
            WAIT:      state_next = LOAD;
            GAME_OVER: state_next = GAME_OVER;
            GAME_WON:  state_next = GAME_WON;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_pos     <= '0;
            y_pos     <= RESET_Y;
            blk_w     <= 8'(BLOCK_W);
            dir       <= GO_LEFT;
            row       <= '0;
            prev_x    <= '0;
            prev_w    <= 8'(BLOCK_W);
            over_flag <= 1'b0;
            won_flag  <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    y_pos <= bus.new_y_position;
                    dir   <= bus.new_direction;
                    x_pos <= ({1'b0, bus.new_x_position} > right_limit) ? right_limit[7:0]
                                                                         : bus.new_x_position;
                end
                MOVE: begin
                    if (step) begin
                        // Bounce: reverse and take the step in the new direction on the same tick.
                        if (dir == GO_RIGHT) begin
                            if ({1'b0, x_pos} >= right_limit) begin
                                dir   <= GO_LEFT;
                                x_pos <= x_pos - 8'd1;
                            end else begin
                                x_pos <= x_pos + 8'd1;
                            end
                        end else if (x_pos == 8'd0) begin
                            dir   <= GO_RIGHT;
                            x_pos <= x_pos + 8'd1;
                        end else begin
                            x_pos <= x_pos - 8'd1;
                        end
                    end
                end
                CHECK: begin
                    if (overlap_ok) begin
                        x_pos  <= trim_x;
                        blk_w  <= trim_w;
                        prev_x <= trim_x;
                        prev_w <= trim_w;
                        if (last_row) won_flag <= 1'b1;
                    end else begin
                        over_flag <= 1'b1;
                    end
                end
                NEXT:    row <= row + 3'd1;
                default: ;
            endcase
        end
    end

    assign bus.x_position  = x_pos;
    assign bus.y_position  = y_pos;
    assign bus.block_width = blk_w;
    assign bus.game_over   = over_flag;
    assign bus.game_won    = won_flag;
    assign bus.inc_row     = (state == NEXT);
    assign bus.busy        = !((state == IDLE) || (state == GAME_OVER) || (state == GAME_WON));

`ifdef BLOCK_MOVER_PERFECT_EN
    logic [2:0] perfect_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            perfect_cnt <= '0;
        end else if ((state == CHECK) && (row != 3'd0) && (x_pos == prev_x) &&
                     (blk_w == prev_w) && (perfect_cnt != 3'd7)) begin
            perfect_cnt <= perfect_cnt + 3'd1;
        end
    end

    assign bus.perfect_count = perfect_cnt;
`else
    assign bus.perfect_count = 3'd0;
`endif

endmodule

// File: tb/tb_block_mover.sv
// Self-checking bench for block_mover: directed scenarios with literal expectations,
// then randomized play, all compared every cycle against a game-level reference model.
module tb_block_mover;
    import tower_pkg::*;

    logic clk = 1'b0;
    logic reset;

    block_mover_if bif ();

    block_mover dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model (game-level view) ----------------
    bit m_valid = 1'b0;
    bit m_idle, m_moving, m_over, m_won, m_check_due, m_inc;
    int m_load_in;
    int m_x, m_y, m_w, m_dir, m_row, m_px, m_pw, m_frames, m_perfect;

    task automatic model_reset();
        m_idle = 1; m_moving = 0; m_over = 0; m_won = 0; m_check_due = 0; m_inc = 0;
        m_load_in = 0;
        m_x = 0; m_y = 104; m_w = BLOCK_W; m_dir = 0; m_row = 0;
        m_px = 0; m_pw = BLOCK_W; m_frames = 0; m_perfect = 0;
    endtask

    task automatic model_load();
        int lim;
        lim = SCREEN_W - m_w;
        m_x = (int'(bif.new_x_position) > lim) ? lim : int'(bif.new_x_position);
        m_y = int'(bif.new_y_position);
        m_dir = int'(bif.new_direction);
        m_frames = 0;
        m_moving = 1;
    endtask

    task automatic model_move_one();
        if (m_dir == 1) begin
            if (m_x == SCREEN_W - m_w) begin m_dir = 0; m_x--; end
            else m_x++;
        end else begin
            if (m_x == 0) begin m_dir = 1; m_x++; end
            else m_x--;
        end
    endtask

    task automatic model_check();
        int l, r;
        bit ok;
        ok = 1;
        if (m_row != 0) begin
            l = (m_x > m_px) ? m_x : m_px;
            r = (m_x + m_w < m_px + m_pw) ? m_x + m_w : m_px + m_pw;
            if (r <= l) ok = 0;
            else begin
                if (m_x == m_px && m_w == m_pw && m_perfect < 7) m_perfect++;
                m_x = l;
                m_w = r - l;
            end
        end
        if (!ok) m_over = 1;
        else begin
            m_px = m_x; m_pw = m_w;
            if (m_row == NUM_ROWS - 1) m_won = 1;
            else begin m_inc = 1; m_row++; m_load_in = 3; end
        end
    endtask

    always @(posedge clk) begin : model_step
        bit was_moving, was_check;
        int period;
        was_moving = m_moving;
        was_check  = m_check_due;
        if (reset) begin
            model_reset();
            m_valid = 1;
        end else if (m_valid) begin
            m_inc = 0;
            m_check_due = 0;
            if (m_load_in > 0) begin
                m_load_in--;
                if (m_load_in == 0) model_load();
            end
            if (was_check) model_check();
            if (was_moving) begin
                if (bif.drop) begin
                    m_moving = 0;
                    m_check_due = 1;
                end else if (bif.frame_tick) begin
                    period = (bif.difficulty == 3'd0) ? 1 : int'(bif.difficulty);
                    m_frames++;
                    if (m_frames >= period) begin
                        model_move_one();
                        m_frames = 0;
                    end
                end
            end
            if (m_idle && bif.start) begin
                m_idle = 0;
                m_load_in = 1;
            end
        end
    end

    function automatic int exp_perfect();
`ifdef BLOCK_MOVER_PERFECT_EN
        return m_perfect;
`else
        return 0;
`endif
    endfunction

    // Compare every output each cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("x_position",    bif.x_position,    m_x);
            check("y_position",    bif.y_position,    m_y);
            check("block_width",   bif.block_width,   m_w);
            check("inc_row",       bif.inc_row,       m_inc);
            check("busy",          bif.busy,          !(m_idle || m_over || m_won));
            check("game_over",     bif.game_over,     m_over);
            check("game_won",      bif.game_won,      m_won);
            check("perfect_count", bif.perfect_count, exp_perfect());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycle(input bit st, input bit tk, input bit dr);
        bif.start = st; bif.frame_tick = tk; bif.drop = dr;
        @(posedge clk);
        #1;
        bif.start = 1'b0; bif.frame_tick = 1'b0; bif.drop = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic start_row(input int x, input bit d);
        bif.new_x_position = 8'(x);
        bif.new_direction = d;
        cycle(1, 0, 0);
        cycle(0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        bif.start = 0; bif.frame_tick = 0; bif.drop = 0;
        bif.difficulty = MAX; bif.new_direction = GO_RIGHT;
        bif.new_x_position = 8'd0; bif.new_y_position = 7'd50;
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        reset = 1'b0;

        // 1. reset values, then 10 ticks at difficulty 1
        check("reset x", bif.x_position, 0);
        check("reset y", bif.y_position, 104);
        check("reset w", bif.block_width, 16);
        check("reset busy", bif.busy, 0);
        start_row(0, GO_RIGHT);
        check("load y", bif.y_position, 50);
        repeat (10) cycle(0, 1, 0);
        check("t1 x", bif.x_position, 10);
        check("t1 busy", bif.busy, 1);
        check("t1 model x", m_x, 10);

        // 2. difficulty 4: 8 ticks -> 2 pixels; difficulty 0 acts as 1
        bif.difficulty = LOW;
        repeat (8) cycle(0, 1, 0);
        check("t2 diff4 x", bif.x_position, 12);
        bif.difficulty = 3'd0;
        repeat (3) cycle(0, 1, 0);
        check("t2 diff0 x", bif.x_position, 15);
        check("t2 model x", m_x, 15);

        // 3. right-edge bounce, left-edge bounce, load clamp
        bif.difficulty = MAX;
        do_reset();
        start_row(143, GO_RIGHT);
        cycle(0, 1, 0);
        check("t3 right edge", bif.x_position, 144);
        cycle(0, 1, 0);
        check("t3 right bounce", bif.x_position, 143);
        check("t3 model bounce", m_x, 143);
        do_reset();
        start_row(1, GO_LEFT);
        cycle(0, 1, 0);
        check("t3 left edge", bif.x_position, 0);
        cycle(0, 1, 0);
        check("t3 left bounce", bif.x_position, 1);
        do_reset();
        start_row(200, GO_RIGHT);
        check("t3 clamp", bif.x_position, 144);

        // 4. row 0 at 20, row 1 at 28 -> width 8 at x 28
        do_reset();
        start_row(20, GO_RIGHT);
        cycle(0, 0, 1);
        check("t4 inc early", bif.inc_row, 0);
        cycle(0, 0, 0);
        check("t4 inc row0", bif.inc_row, 1);
        bif.new_x_position = 8'd28;
        cycle(0, 0, 0);
        check("t4 inc width", bif.inc_row, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check("t4 load x", bif.x_position, 28);
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        check("t4 inc row1", bif.inc_row, 1);
        check("t4 width", bif.block_width, 8);
        check("t4 x", bif.x_position, 28);

        // 5. zero overlap -> game over, further inputs ignored
        do_reset();
        start_row(0, GO_RIGHT);
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        bif.new_x_position = 8'd16;
        repeat (3) cycle(0, 0, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        check("t5 game_over", bif.game_over, 1);
        check("t5 no inc", bif.inc_row, 0);
        repeat (5) cycle(1, 1, 1);
        check("t5 frozen x", bif.x_position, 16);
        check("t5 busy", bif.busy, 0);

        // 6. seven aligned drops -> win
        do_reset();
        start_row(40, GO_RIGHT);
        bif.new_x_position = 8'd40;
        for (int r = 0; r < NUM_ROWS; r++) begin
            cycle(0, 0, 1);
            cycle(0, 0, 0);
            if (r < NUM_ROWS - 1) repeat (3) cycle(0, 0, 0);
        end
        check("t6 game_won", bif.game_won, 1);
        check("t6 width", bif.block_width, 16);
`ifdef BLOCK_MOVER_PERFECT_EN
        check("t6 perfect", bif.perfect_count, 6);
`else
        check("t6 perfect", bif.perfect_count, 0);
`endif
        repeat (3) cycle(1, 1, 1);
        check("t6 busy", bif.busy, 0);

        // 7. drop beats tick; reset in MOVE and in CHECK
        do_reset();
        start_row(30, GO_RIGHT);
        cycle(0, 1, 1);
        check("t7 drop wins", bif.x_position, 30);
        cycle(0, 0, 0);
        check("t7 after check", bif.x_position, 30);
        do_reset();
        start_row(30, GO_RIGHT);
        repeat (3) cycle(0, 1, 0);
        check("t7 moved", bif.x_position, 33);
        do_reset();
        check("t7 rst move x", bif.x_position, 0);
        check("t7 rst move busy", bif.busy, 0);
        start_row(30, GO_RIGHT);
        cycle(0, 0, 1);
        do_reset();
        check("t7 rst check inc", bif.inc_row, 0);
        check("t7 rst check y", bif.y_position, 104);
        cycle(0, 0, 0);
        check("t7 rst check inc2", bif.inc_row, 0);

        // Randomized play against the model
        for (int c = 0; c < 20000; c++) begin
            if ($urandom_range(0, 9) == 0) bif.difficulty = 3'($urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 3) == 0) bif.new_x_position = 8'($urandom);
                else bif.new_x_position = 8'(m_px + int'($urandom_range(0, 3)));
                bif.new_direction = 1'($urandom);
                bif.new_y_position = 7'($urandom);
            end
            reset = ($urandom_range(0, 999) == 0) ||
                    ((m_over || m_won) && $urandom_range(0, 19) == 0);
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 5) == 0);
        end
        reset = 1'b0;
        cycle(0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
